// File: rtl/spi_reg_master_if.sv
// Host handshake and SPI pin bundle for spi_reg_master.
interface spi_reg_master_if #(
    parameter int ADDR_W = 3,
    parameter int REG_W  = 8
);
    logic [1:0]        mode;
    logic              start;
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [REG_W-1:0]  wdata;
    logic              busy;
    logic              done;
    logic [REG_W-1:0]  rdata;
    logic [REG_W-1:0]  status_o;
    logic              spi_clk;
    logic              spi_mosi;
    logic              spi_miso;
    logic              spi_cs_n;

    modport master (
        input  mode, start, rw, addr, wdata, spi_miso,
        output busy, done, rdata, status_o, spi_clk, spi_mosi, spi_cs_n
    );

    modport slave (
        output mode, start, rw, addr, wdata, spi_miso,
        input  busy, done, rdata, status_o, spi_clk, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_reg_master.sv
// SPI controller issuing two-byte register frames: command/status, then data.
module spi_reg_master #(
    parameter int ADDR_W  = 3,
    parameter int REG_W   = 8,
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    spi_reg_master_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_BYTE0, S_GAP, S_BYTE1, S_HOLD, S_CSHIGH
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [3:0]         edge_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic               cpha_q;
    logic               rw_q;
    logic [REG_W-1:0]   wdata_q;
    logic [REG_W-1:0]   tx_shift;
    logic [REG_W-1:0]   rx_shift;
    logic               sclk_q;
    logic               done_q;
    logic [REG_W-1:0]   rdata_q;
    logic [REG_W-1:0]   status_q;

    logic               in_byte, hp_end, sclk_edge, lead, trail;
    logic               do_sample, do_shift, byte_end, cs_active;
    logic [REG_W-1:0]   cmd_byte, rx_next, rx_fin;

    assign bus.spi_clk  = sclk_q;
    assign bus.spi_mosi = tx_shift[REG_W-1];
    assign bus.done     = done_q;
    assign bus.rdata    = rdata_q;
    assign bus.status_o = status_q;

    // State register; frozen while ena is low.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            state <= S_IDLE;
        else if (ena)
            state <= state_nxt;
    end

    // Next-state sequencing through the frame phases.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_SETUP;
            S_SETUP:  if (hp_end)    state_nxt = S_BYTE0;
            S_BYTE0:  if (byte_end)  state_nxt = S_GAP;
            S_GAP:    if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nxt = S_BYTE1;
            S_BYTE1:  if (byte_end)  state_nxt = S_HOLD;
            S_HOLD:   if (hp_end)    state_nxt = S_CSHIGH;
            S_CSHIGH: if (hp_end)    state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Output decode: chip select, busy and the per-edge shift/sample strobes.
    always_comb begin
        in_byte   = (state == S_BYTE0) || (state == S_BYTE1);
        hp_end    = (div_cnt == DIV_W'(CLK_DIV - 1));
        sclk_edge = in_byte && hp_end;
        lead      = sclk_edge && !edge_cnt[0];
        trail     = sclk_edge &&  edge_cnt[0];
        // CPHA=1 leaves the first bit in place: the slave samples it on the first trailing edge.
        do_sample = cpha_q ? trail : lead;
        do_shift  = cpha_q ? (lead && (edge_cnt != 4'd0)) : trail;
        byte_end  = sclk_edge && (edge_cnt == 4'd15);
        cs_active = state inside {S_SETUP, S_BYTE0, S_GAP, S_BYTE1, S_HOLD};
        bus.spi_cs_n = !cs_active;
        bus.busy     = cs_active;
        cmd_byte = '0;
        cmd_byte[REG_W-1]    = bus.rw;
        cmd_byte[ADDR_W-1:0] = bus.addr;
        rx_next = {rx_shift[REG_W-2:0], bus.spi_miso};
        // The final CPHA=1 sample lands on the byte's last edge, so fold it in here.
        rx_fin  = do_sample ? rx_next : rx_shift;
    end

    // Datapath: counters, SCLK generation, shift registers and result capture.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            gap_cnt  <= '0;
            cpha_q   <= 1'b0;
            rw_q     <= 1'b0;
            wdata_q  <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            sclk_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            status_q <= '0;
        end else if (ena) begin
            done_q <= (state == S_HOLD) && hp_end;

            if (state inside {S_SETUP, S_BYTE0, S_BYTE1, S_HOLD, S_CSHIGH})
                div_cnt <= hp_end ? '0 : div_cnt + DIV_W'(1);
            else
                div_cnt <= '0;

            if (in_byte)
                edge_cnt <= sclk_edge ? edge_cnt + 4'd1 : edge_cnt;
            else
                edge_cnt <= '0;

            gap_cnt <= (state == S_GAP) ? gap_cnt + GAP_W'(1) : '0;

            if (state == S_IDLE) begin
                sclk_q <= bus.mode[1];
                if (bus.start) begin
                    cpha_q   <= bus.mode[0];
                    rw_q     <= bus.rw;
                    wdata_q  <= bus.wdata;
                    tx_shift <= cmd_byte;
                end
            end

            if (sclk_edge)
                sclk_q <= ~sclk_q;
            if (do_sample)
                rx_shift <= rx_next;
            if (do_shift)
                tx_shift <= {tx_shift[REG_W-2:0], 1'b0};

            if (byte_end && (state == S_BYTE0)) begin
                status_q <= rx_fin;
                tx_shift <= rw_q ? wdata_q : '0;
            end
            if (byte_end && (state == S_BYTE1)) begin
                if (!rw_q)
                    rdata_q <= rx_fin;
                tx_shift <= '0;
            end
        end
    end
endmodule

// File: tb/tb_spi_reg_master.sv
// Directed bench for spi_reg_master with an SPI register slave model and scoreboard.
module tb_spi_reg_master;
    logic clk = 1'b0;
    logic rstb;
    logic ena;

    always #5 clk = ~clk;

    spi_reg_master_if #(.ADDR_W(3), .REG_W(8)) if1 ();
    spi_reg_master_if #(.ADDR_W(3), .REG_W(8)) if2 ();

    spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(4), .GAP_CYC(8)) dut (
        .clk(clk), .rstb(rstb), .ena(ena), .bus(if1.master)
    );

    spi_reg_master #(.ADDR_W(3), .REG_W(8), .CLK_DIV(2), .GAP_CYC(1)) dut2 (
        .clk(clk), .rstb(rstb), .ena(ena), .bus(if2.master)
    );

    // ---------------- slave model (dut) ----------------
    logic [7:0] sl_reg [8] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] sl_status = 8'h81;
    logic [7:0] sl_rx = 8'h00, sl_cmd = 8'h00, sl_b1 = 8'h00;
    logic [1:0] sl_mode;
    logic       sl_miso = 1'b0;
    logic       sl_prev_clk = 1'b0;
    int         sl_edges = 0, sl_byte = 0, sl_total_edges = 0;

    assign if1.spi_miso = sl_miso;
    assign if2.spi_miso = 1'b1;

    // Mode-aware slave: samples MOSI on its sample edge and presents MISO bit by edge count.
    always @(if1.spi_clk or if1.spi_cs_n) begin : slave_model
        int idx;
        logic [7:0] txb;
        if (if1.spi_cs_n !== 1'b0) begin
            sl_edges = 0;
            sl_byte  = 0;
        end else if (if1.spi_clk !== sl_prev_clk) begin
            sl_total_edges++;
            if ((if1.spi_clk == 1'b1) == (sl_mode[1] == sl_mode[0]))
                sl_rx = {sl_rx[6:0], if1.spi_mosi};
            sl_edges++;
            if (sl_edges == 16) begin
                sl_edges = 0;
                if (sl_byte == 0) begin
                    sl_cmd  = sl_rx;
                    sl_byte = 1;
                end else if (sl_byte == 1) begin
                    sl_b1   = sl_rx;
                    sl_byte = 2;
                    if (sl_cmd[7])
                        sl_reg[sl_cmd[2:0]] = sl_rx;
                end
            end
        end
        sl_prev_clk = if1.spi_clk;
        txb = (sl_byte == 0) ? sl_status : (sl_cmd[7] ? 8'h00 : sl_reg[sl_cmd[2:0]]);
        if (sl_mode[0])
            idx = (sl_edges == 0) ? 7 : 7 - ((sl_edges - 1) / 2);
        else
            idx = 7 - (sl_edges / 2);
        sl_miso = txb[idx];
    end

    // ---------------- monitors ----------------
    int cs_cur = 0, cs_last = 0, done_cnt = 0;
    int cs2_cur = 0, cs2_last = 0, done2_cnt = 0;
    logic [15:0] mosi2 = 16'h0000;

    // Chip-select low time and done pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (if1.spi_cs_n === 1'b0) cs_cur++;
        else begin
            if (cs_cur != 0) cs_last = cs_cur;
            cs_cur = 0;
        end
        if (if2.spi_cs_n === 1'b0) cs2_cur++;
        else begin
            if (cs2_cur != 0) cs2_last = cs2_cur;
            cs2_cur = 0;
        end
        if (if1.done === 1'b1) done_cnt++;
        if (if2.done === 1'b1) done2_cnt++;
    end

    // Mode-0 MOSI capture for the second instance.
    always @(posedge if2.spi_clk)
        if (if2.spi_cs_n === 1'b0) mosi2 = {mosi2[14:0], if2.spi_mosi};

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] status;
        logic [7:0] rdata;
        int         cs_low;
    } exp_t;

    exp_t sb[$];
    logic [7:0] m_reg [8] = '{8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] m_rdata = 8'h00;
    int n_cmp = 0, n_bad = 0;
    int base_done = 0, base_edges = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] m, input logic w, input logic [2:0] a,
                         input logic [7:0] d, input int ext);
        exp_t e;
        e.b0     = {w, 4'b0000, a};
        e.b1     = w ? d : 8'h00;
        e.status = 8'h81;
        if (w) m_reg[a] = d;
        else   m_rdata  = m_reg[a];
        e.rdata  = m_rdata;
        e.cs_low = 34 * 4 + 8 + ext;
        sb.push_back(e);
        sl_mode  = m;
        if1.mode = m;
        repeat (2) @(negedge clk);
        chk("idle_sclk_cpol", if1.spi_clk, m[1]);
        base_done  = done_cnt;
        base_edges = sl_total_edges;
        if1.rw    = w;
        if1.addr  = a;
        if1.wdata = d;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (if1.done !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_done_timeout"}, n < 2000, 1);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        repeat (8) @(negedge clk);
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_status"}, if1.status_o, e.status);
            chk({tag, "_rdata"},  if1.rdata,    e.rdata);
            chk({tag, "_mosi_b0"}, sl_cmd, e.b0);
            chk({tag, "_mosi_b1"}, sl_b1,  e.b1);
            chk({tag, "_cs_low"},  cs_last, e.cs_low);
        end
        chk({tag, "_done_once"}, done_cnt - base_done, 1);
        chk({tag, "_sclk_edges"}, sl_total_edges - base_edges, 32);
        chk({tag, "_sclk_idle"}, if1.spi_clk, sl_mode[1]);
        chk({tag, "_busy_low"}, if1.busy, 1'b0);
        chk({tag, "_cs_high"}, if1.spi_cs_n, 1'b1);
    endtask

    task automatic do_frame(input string tag, input logic [1:0] m, input logic w,
                            input logic [2:0] a, input logic [7:0] d);
        issue(m, w, a, d, 0);
        wait_done(tag);
        check_frame(tag);
    endtask

    initial begin
        exp_t drop;
        int   frz_edges;
        int   n;
        rstb = 1'b0;
        ena  = 1'b1;
        sl_mode = 2'b00;
        if1.mode = 2'b00; if1.start = 1'b0; if1.rw = 1'b0; if1.addr = '0; if1.wdata = '0;
        if2.mode = 2'b00; if2.start = 1'b0; if2.rw = 1'b0; if2.addr = '0; if2.wdata = '0;
        repeat (3) @(negedge clk);

        chk("rst_cs_n",   if1.spi_cs_n, 1'b1);
        chk("rst_sclk",   if1.spi_clk,  1'b0);
        chk("rst_mosi",   if1.spi_mosi, 1'b0);
        chk("rst_busy",   if1.busy,     1'b0);
        chk("rst_done",   if1.done,     1'b0);
        chk("rst_rdata",  if1.rdata,    8'h00);
        chk("rst_status", if1.status_o, 8'h00);
        rstb = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0 write then read of a preloaded register.
        do_frame("m0_wr5", 2'b00, 1'b1, 3'd5, 8'hA5);
        do_frame("m0_rd3", 2'b00, 1'b0, 3'd3, 8'h00);

        // Write/read-back in the remaining modes.
        for (int m = 1; m < 4; m++) begin
            do_frame($sformatf("m%0d_wr2", m), 2'(m), 1'b1, 3'd2, 8'h5A);
            do_frame($sformatf("m%0d_rd2", m), 2'(m), 1'b0, 3'd2, 8'h00);
        end

        // ena held low for 20 cycles in the middle of byte 0.
        issue(2'b00, 1'b1, 3'd4, 8'h77, 20);
        repeat (30) @(negedge clk);
        ena = 1'b0;
        frz_edges = sl_total_edges;
        repeat (20) @(negedge clk);
        chk("frz_busy",   if1.busy, 1'b1);
        chk("frz_cs_n",   if1.spi_cs_n, 1'b0);
        chk("frz_edges",  sl_total_edges - frz_edges, 0);
        chk("frz_nodone", done_cnt - base_done, 0);
        ena = 1'b1;
        wait_done("ena_wr4");
        check_frame("ena_wr4");
        do_frame("ena_rd4", 2'b00, 1'b0, 3'd4, 8'h00);

        // start during busy (with a mode change) and during CSHIGH is ignored.
        issue(2'b00, 1'b1, 3'd6, 8'h3E, 0);
        repeat (40) @(negedge clk);
        if1.mode = 2'b11; if1.rw = 1'b0; if1.addr = 3'd3; if1.wdata = 8'hFF;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        wait_done("ign_wr6");
        if1.mode  = 2'b00;
        if1.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0;
        check_frame("ign_wr6");
        repeat (10) @(negedge clk);
        chk("ign_no_restart", if1.busy, 1'b0);
        chk("ign_single_done", done_cnt - base_done, 1);
        do_frame("ign_rd6", 2'b00, 1'b0, 3'd6, 8'h00);

        // Asynchronous reset in the middle of byte 1.
        issue(2'b00, 1'b1, 3'd7, 8'h99, 0);
        repeat (100) @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("arst_cs_n",   if1.spi_cs_n, 1'b1);
        chk("arst_sclk",   if1.spi_clk,  1'b0);
        chk("arst_busy",   if1.busy,     1'b0);
        chk("arst_rdata",  if1.rdata,    8'h00);
        chk("arst_status", if1.status_o, 8'h00);
        drop = sb.pop_back();
        m_reg[7] = 8'h00;
        m_rdata  = 8'h00;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (10) @(negedge clk);
        chk("arst_no_done", done_cnt - base_done, 0);
        do_frame("arst_wr1", 2'b00, 1'b1, 3'd1, 8'h11);

        // Minimum divider / gap instance.
        if2.rw = 1'b1; if2.addr = 3'd1; if2.wdata = 8'h11;
        if2.start = 1'b1;
        @(negedge clk);
        if2.start = 1'b0;
        n = 0;
        while (if2.done !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("d2_done_timeout", n < 1000, 1);
        repeat (6) @(negedge clk);
        chk("d2_cs_low", cs2_last, 69);
        chk("d2_mosi",   mosi2, 16'h8111);
        chk("d2_status", if2.status_o, 8'hFF);
        chk("d2_rdata",  if2.rdata, 8'h00);
        chk("d2_done_once", done2_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
